apb_slave_sel_ctrl: RTL and testbench
=====================================

// Module: apb_slave_sel_ctrl
// PURPOSE
//  Sequences the APB side of the AHB-to-APB bridge. It decodes the bridge's paddr into
//  one-hot psel_s per peripheral and tracks each APB transfer through SETUP/ACCESS.
//  It muxes the selected slave's pready/pslverr/prdata back to the bridge and bounds
//  every access with a wait-state watchdog, so a hung or disabled slave cannot stall AHB.
//  It sits between the bridge's APB master outputs and the NUM_SLV peripherals.
// PARAMETERS
//  NUM_SLV      4    number of APB slaves (2..16)
//  IDX_W        2    width of slave index = clog2(NUM_SLV)
//  SEL_LSB      12   paddr bit where the slave index field starts
//  TIMEOUT      16   max ACCESS cycles with pready low before forced error (2..2**TO_W-1)
//  TO_W         5    width of wait-state counter
// PORTS
//  hclk         in   1                    system clock
//  hreset_n     in   1                    async active-low reset
//  psel_en      in   1                    bridge APB select
//  penable      in   1                    bridge APB enable
//  paddr        in   `PADDR_WIDTH         bridge APB address
//  slv_en       in   NUM_SLV              per-slave enable mask (0 = respond error)
//  pready_s     in   NUM_SLV              per-slave pready
//  pslverr_s    in   NUM_SLV              per-slave pslverr
//  prdata_s     in   NUM_SLV*`APB_DATA_WIDTH  per-slave read data, slave i at [i*DW +: DW]
//  psel_s       out  NUM_SLV              one-hot slave select
//  pready_x     out  1                    muxed/forced ready to bridge
//  pslverr_x    out  1                    muxed/forced error to bridge
//  prdata_x     out  `APB_DATA_WIDTH      muxed read data to bridge
//  to_pulse     out  1                    1-cycle pulse on watchdog expiry
//  to_cnt       out  8                    saturating count of watchdog expiries
//  err_idx      out  IDX_W                index of the slave that last timed out or was blocked
// BEHAVIOUR
//  Reset (async, hreset_n=0): FSM=IDLE, wait counter=0, to_cnt=0, err_idx=0, to_pulse=0.
//   All combinational outputs then evaluate to 0 (psel_s, pready_x, pslverr_x, prdata_x).
//  Reset mid-transfer aborts immediately. No response is given and no to_cnt increment occurs.
//  Decode: idx = paddr[SEL_LSB +: IDX_W].
//   The slave is valid when idx < NUM_SLV and slv_en[idx]=1.
//  FSM states and transitions:
//   IDLE:   psel_en=1 -> SETUP, latching idx and valid into cur_idx/cur_vld.
//   SETUP:  psel_s[cur_idx]=cur_vld. pready_x=0. Always -> ACCESS on the next cycle.
//   ACCESS: psel_s[cur_idx]=cur_vld.
//    cur_vld=0: pready_x=1, pslverr_x=1 in the first ACCESS cycle (zero waits).
//     err_idx<=cur_idx. No to_pulse.
//    cur_vld=1: pready_x=pready_s[cur_idx], pslverr_x=pready_s&pslverr_s[cur_idx].
//     prdata_x=prdata_s[cur_idx] whenever pready_x=1, else 0.
//    pready low: wait counter +1 per cycle.
//    Counter = TIMEOUT-1 with pready still low: forced pready_x=1, pslverr_x=1, prdata_x=0.
//     to_pulse=1 the next cycle. to_cnt+1, saturating at 255. err_idx<=cur_idx.
//    Real pready in the same cycle as expiry: the real response wins, with no timeout.
//    On any pready_x=1: counter cleared.
//     psel_en=1 with penable=0 next -> SETUP (back-to-back, re-latch idx).
//     Otherwise -> IDLE.
//    psel_en dropping while in ACCESS is a protocol violation: -> IDLE, counter cleared,
//     no event.
//  Latency: a valid slave adds 0 cycles of its own.
//   A timed-out access completes in exactly TIMEOUT ACCESS cycles.
//  psel_s is never multi-hot and is 0 in IDLE.
//   paddr changes outside SETUP do not affect cur_idx.
//  pready_s/pslverr_s of unselected slaves are ignored.
// TESTING
//  1 Write idx1, slv_en=4'hF, pready_s[1] high in the first ACCESS cycle ->
//    psel_s=0010 for 2 cycles, pready_x=1, pslverr_x=0, to_cnt=0.
//  2 Read idx2, slave waits 3 cycles, prdata_s[2]=32'hA5A5_0001 ->
//    pready_x rises in ACCESS cycle 4, prdata_x=A5A5_0001, no to_pulse.
//  3 Access idx3 with pready_s[3] stuck at 0, TIMEOUT=16 ->
//    pready_x=pslverr_x=1 in ACCESS cycle 16, to_pulse once, to_cnt=1, err_idx=3.
//  4 slv_en=4'b1011, access idx2 -> psel_s stays 0, error in the first ACCESS cycle,
//    err_idx=2, to_cnt unchanged.
//  5 Real pready in ACCESS cycle 16 (the expiry cycle) ->
//    pslverr_x=pslverr_s, no to_pulse.
//    Assert hreset_n=0 during ACCESS -> all outputs 0 at once, FSM IDLE.
//  6 Run 256 forced timeouts -> to_cnt saturates at 255.
//    Back-to-back accesses idx0 then idx1 -> psel_s never multi-hot.

Source files
------------

// File: rtl/apb_slave_sel_ctrl.sv
// APB-side sequencer for the AHB-to-APB bridge: decodes paddr into one-hot slave selects,
// muxes the selected slave's response back, and bounds every access with a wait-state watchdog.
`timescale 1ns/1ps
`ifndef PADDR_WIDTH
`define PADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

module apb_slave_sel_ctrl #(
  parameter int NUM_SLV = 4,
  parameter int IDX_W   = 2,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic                               hclk,
  input  logic                               hreset_n,
  input  logic                               psel_en,
  input  logic                               penable,
  input  logic [`PADDR_WIDTH-1:0]            paddr,
  input  logic [NUM_SLV-1:0]                 slv_en,
  input  logic [NUM_SLV-1:0]                 pready_s,
  input  logic [NUM_SLV-1:0]                 pslverr_s,
  input  logic [NUM_SLV*`APB_DATA_WIDTH-1:0] prdata_s,
  output logic [NUM_SLV-1:0]                 psel_s,
  output logic                               pready_x,
  output logic                               pslverr_x,
  output logic [`APB_DATA_WIDTH-1:0]         prdata_x,
  output logic                               to_pulse,
  output logic [7:0]                         to_cnt,
  output logic [IDX_W-1:0]                   err_idx
);

  localparam int DW = `APB_DATA_WIDTH;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  cur_idx, cur_idx_nxt;
  logic              cur_vld, cur_vld_nxt;
  logic [TO_W-1:0]   wait_cnt, wait_cnt_nxt;
  logic [IDX_W-1:0]  dec_idx;
  logic              dec_vld;
  logic              to_evt;
  logic              err_evt;

  assign dec_idx = paddr[SEL_LSB +: IDX_W];

  // An index beyond the populated slaves is treated like a disabled slave.
  always_comb begin
    dec_vld = 1'b0;
    if (int'(dec_idx) < NUM_SLV) dec_vld = slv_en[dec_idx];
  end

  always_comb begin
    state_nxt    = state;
    cur_idx_nxt  = cur_idx;
    cur_vld_nxt  = cur_vld;
    wait_cnt_nxt = '0;
    psel_s       = '0;
    pready_x     = 1'b0;
    pslverr_x    = 1'b0;
    prdata_x     = '0;
    to_evt       = 1'b0;
    err_evt      = 1'b0;
    case (state)
      IDLE: begin
        if (psel_en) begin
          state_nxt   = SETUP;
          cur_idx_nxt = dec_idx;
          cur_vld_nxt = dec_vld;
        end
      end
      SETUP: begin
        if (cur_vld) psel_s[cur_idx] = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        if (cur_vld) psel_s[cur_idx] = 1'b1;
        if (!psel_en) begin
          state_nxt = IDLE;
        end else begin
          // A real pready in the expiry cycle takes priority over the watchdog.
          if (!cur_vld) begin
            pready_x  = 1'b1;
            pslverr_x = 1'b1;
            err_evt   = 1'b1;
          end else if (pready_s[cur_idx]) begin
            pready_x  = 1'b1;
            pslverr_x = pslverr_s[cur_idx];
            prdata_x  = prdata_s[cur_idx*DW +: DW];
          end else if (wait_cnt == TO_LAST) begin
            pready_x  = 1'b1;
            pslverr_x = 1'b1;
            to_evt    = 1'b1;
            err_evt   = 1'b1;
          end else begin
            wait_cnt_nxt = wait_cnt + 1'b1;
          end
          if (pready_x) begin
            if (!penable) begin
              state_nxt   = SETUP;
              cur_idx_nxt = dec_idx;
              cur_vld_nxt = dec_vld;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state    <= IDLE;
      cur_idx  <= '0;
      cur_vld  <= 1'b0;
      wait_cnt <= '0;
      to_pulse <= 1'b0;
      to_cnt   <= '0;
      err_idx  <= '0;
    end else begin
      state    <= state_nxt;
      cur_idx  <= cur_idx_nxt;
      cur_vld  <= cur_vld_nxt;
      wait_cnt <= wait_cnt_nxt;
      to_pulse <= to_evt;
      if (to_evt && (to_cnt != 8'hFF)) to_cnt <= to_cnt + 8'd1;
      if (err_evt) err_idx <= cur_idx;
    end
  end

endmodule

// File: tb/tb_apb_slave_sel_ctrl.sv
// Directed bench for apb_slave_sel_ctrl: table of single accesses plus hand-written
// sequences for back-to-back transfers, reset mid-access and to_cnt saturation.
`timescale 1ns/1ps

module tb_apb_slave_sel_ctrl;

  logic         hclk = 1'b0;
  logic         hreset_n = 1'b1;
  logic         psel_en = 1'b0;
  logic         penable = 1'b0;
  logic [31:0]  paddr = '0;
  logic [3:0]   slv_en = 4'hF;
  logic [3:0]   pready_s = '0;
  logic [3:0]   pslverr_s = '0;
  logic [127:0] prdata_s = '0;
  logic [3:0]   psel_s;
  logic         pready_x;
  logic         pslverr_x;
  logic [31:0]  prdata_x;
  logic         to_pulse;
  logic [7:0]   to_cnt;
  logic [1:0]   err_idx;

  int checks = 0;
  int failures = 0;
  int pulse_seen = 0;
  int multihot = 0;

  apb_slave_sel_ctrl #(
    .NUM_SLV(4), .IDX_W(2), .SEL_LSB(12), .TIMEOUT(16), .TO_W(5)
  ) dut (
    .hclk(hclk), .hreset_n(hreset_n), .psel_en(psel_en), .penable(penable),
    .paddr(paddr), .slv_en(slv_en), .pready_s(pready_s), .pslverr_s(pslverr_s),
    .prdata_s(prdata_s), .psel_s(psel_s), .pready_x(pready_x), .pslverr_x(pslverr_x),
    .prdata_x(prdata_x), .to_pulse(to_pulse), .to_cnt(to_cnt), .err_idx(err_idx)
  );

  always #5 hclk = ~hclk;

  always @(negedge hclk) begin
    #2;
    if (to_pulse) pulse_seen++;
    if ($countones(psel_s) > 1) multihot++;
  end

  typedef struct {
    logic [1:0]  idx;
    logic [3:0]  en;
    int          waits;
    logic        err;
    logic [31:0] rdata;
    int          cyc;
    logic        xerr;
    logic [31:0] xdata;
    logic [3:0]  xpsel;
    logic        xpulse;
    logic [7:0]  xcnt;
    logic [1:0]  xeidx;
  } vec_t;

  vec_t vec [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Selected slave answers after 'waits' ACCESS cycles; unselected slaves present
  // ready/error/garbage that must be ignored.
  task automatic set_slaves(input logic [1:0] idx, input int k, input int waits,
                            input logic err, input logic [31:0] rdata);
    pready_s  = 4'hF;
    pslverr_s = 4'hF;
    pready_s[idx]  = (k > waits);
    pslverr_s[idx] = err;
    for (int i = 0; i < 4; i++)
      prdata_s[i*32 +: 32] = (i == int'(idx)) ? rdata : (32'hFFFF_0000 | 32'(i));
  endtask

  task automatic do_access(input logic [1:0] idx, input logic [3:0] en, input int waits,
                           input logic err, input logic [31:0] rdata, input bit chained,
                           input bit chain_next, input logic [1:0] next_idx,
                           output int ncyc, output logic gerr, output logic [31:0] gdata,
                           output logic [3:0] gpsel);
    if (!chained) begin
      @(negedge hclk);
      slv_en  = en;
      psel_en = 1'b1;
      penable = 1'b0;
      paddr   = 32'(idx) << 12;
      set_slaves(idx, 0, waits, err, rdata);
    end
    @(negedge hclk);
    penable = 1'b1;
    set_slaves(idx, 0, waits, err, rdata);
    #1 gpsel = psel_s;
    ncyc  = -1;
    gerr  = 1'b0;
    gdata = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge hclk);
      set_slaves(idx, k, waits, err, rdata);
      #1;
      if (pready_x) begin
        ncyc  = k;
        gerr  = pslverr_x;
        gdata = prdata_x;
        if (chain_next) begin
          penable = 1'b0;
          paddr   = 32'(next_idx) << 12;
        end
        break;
      end
    end
    if (!chain_next) begin
      @(negedge hclk);
      psel_en  = 1'b0;
      penable  = 1'b0;
      pready_s = '0;
    end
  endtask

  int          ncyc;
  logic        gerr;
  logic [31:0] gdata;
  logic [3:0]  gpsel;

  initial begin
    vec[0] = '{2'd1, 4'hF,  0, 1'b0, 32'h1234_0001,  1, 1'b0, 32'h1234_0001, 4'b0010, 1'b0, 8'd0, 2'd0};
    vec[1] = '{2'd2, 4'hF,  3, 1'b0, 32'hA5A5_0001,  4, 1'b0, 32'hA5A5_0001, 4'b0100, 1'b0, 8'd0, 2'd0};
    vec[2] = '{2'd3, 4'hF, 99, 1'b0, 32'hDEAD_BEEF, 16, 1'b1, 32'h0,         4'b1000, 1'b1, 8'd1, 2'd3};
    vec[3] = '{2'd2, 4'hB,  0, 1'b0, 32'hBEEF_0002,  1, 1'b1, 32'h0,         4'b0000, 1'b0, 8'd1, 2'd2};
    vec[4] = '{2'd0, 4'hF, 15, 1'b1, 32'h0000_0055, 16, 1'b1, 32'h0000_0055, 4'b0001, 1'b0, 8'd1, 2'd2};
    vec[5] = '{2'd1, 4'hF,  2, 1'b1, 32'h0000_0077,  3, 1'b1, 32'h0000_0077, 4'b0010, 1'b0, 8'd1, 2'd2};
    vec[6] = '{2'd0, 4'hF, 14, 1'b0, 32'h0000_0066, 15, 1'b0, 32'h0000_0066, 4'b0001, 1'b0, 8'd1, 2'd2};
    vec[7] = '{2'd0, 4'hF, 99, 1'b0, 32'h0000_0088, 16, 1'b1, 32'h0,         4'b0001, 1'b1, 8'd2, 2'd0};

    #1 hreset_n = 1'b0;
    repeat (3) @(negedge hclk);
    #1;
    check("rst_psel", 32'(psel_s), 32'h0);
    check("rst_pready", 32'(pready_x), 32'h0);
    check("rst_prdata", prdata_x, 32'h0);
    check("rst_cnt", 32'(to_cnt), 32'h0);
    check("rst_pulse", 32'(to_pulse), 32'h0);
    check("rst_eidx", 32'(err_idx), 32'h0);
    @(negedge hclk);
    hreset_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      do_access(vec[v].idx, vec[v].en, vec[v].waits, vec[v].err, vec[v].rdata, 1'b0, 1'b0,
                2'd0, ncyc, gerr, gdata, gpsel);
      #1;
      check($sformatf("v%0d_cycles", v), 32'(ncyc), 32'(vec[v].cyc));
      check($sformatf("v%0d_err", v), 32'(gerr), 32'(vec[v].xerr));
      check($sformatf("v%0d_rdata", v), gdata, vec[v].xdata);
      check($sformatf("v%0d_psel", v), 32'(gpsel), 32'(vec[v].xpsel));
      check($sformatf("v%0d_pulse", v), 32'(to_pulse), 32'(vec[v].xpulse));
      check($sformatf("v%0d_cnt", v), 32'(to_cnt), 32'(vec[v].xcnt));
      check($sformatf("v%0d_eidx", v), 32'(err_idx), 32'(vec[v].xeidx));
      check($sformatf("v%0d_idle_psel", v), 32'(psel_s), 32'h0);
    end
    @(negedge hclk);
    #3 check("pulse_total", 32'(pulse_seen), 32'd2);

    // Back-to-back: idx0 completes and immediately re-enters SETUP for idx1.
    do_access(2'd0, 4'hF, 1, 1'b0, 32'h0BB0_0000, 1'b0, 1'b1, 2'd1, ncyc, gerr, gdata, gpsel);
    check("b2b0_cycles", 32'(ncyc), 32'd2);
    check("b2b0_psel", 32'(gpsel), 32'h1);
    check("b2b0_rdata", gdata, 32'h0BB0_0000);
    do_access(2'd1, 4'hF, 0, 1'b0, 32'h0BB0_0001, 1'b1, 1'b0, 2'd0, ncyc, gerr, gdata, gpsel);
    check("b2b1_cycles", 32'(ncyc), 32'd1);
    check("b2b1_psel", 32'(gpsel), 32'h2);
    check("b2b1_rdata", gdata, 32'h0BB0_0001);
    check("multihot", 32'(multihot), 32'd0);

    // Reset asserted while a stuck access is waiting in ACCESS.
    @(negedge hclk);
    psel_en = 1'b1;
    penable = 1'b0;
    paddr   = 32'h0000_3000;
    set_slaves(2'd3, 0, 99, 1'b0, 32'h1111_2222);
    @(negedge hclk);
    penable = 1'b1;
    repeat (4) @(negedge hclk);
    #1 check("mid_psel_active", 32'(psel_s), 32'h8);
    hreset_n = 1'b0;
    #1;
    check("mid_rst_psel", 32'(psel_s), 32'h0);
    check("mid_rst_pready", 32'(pready_x), 32'h0);
    check("mid_rst_perr", 32'(pslverr_x), 32'h0);
    check("mid_rst_cnt", 32'(to_cnt), 32'h0);
    check("mid_rst_eidx", 32'(err_idx), 32'h0);
    @(negedge hclk);
    psel_en  = 1'b0;
    penable  = 1'b0;
    pready_s = '0;
    hreset_n = 1'b1;
    repeat (20) @(negedge hclk);
    #3 check("mid_rst_no_pulse", 32'(pulse_seen), 32'd2);

    // to_cnt saturation over 256 forced timeouts.
    for (int i = 0; i < 256; i++) begin
      do_access(2'd3, 4'hF, 99, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, ncyc, gerr, gdata, gpsel);
      #1;
      if (i == 254) check("cnt_255", 32'(to_cnt), 32'd255);
    end
    check("cnt_sat", 32'(to_cnt), 32'd255);
    check("sat_eidx", 32'(err_idx), 32'd3);
    @(negedge hclk);
    #3 check("sat_pulse_total", 32'(pulse_seen), 32'd258);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
